// File: rtl/argo_chan_send_arb.sv
// argo_chan_send_arb
//
// Round-robin send arbiter placed directly in front of one argo_fifo channel.
// Several blocking-send control loops compete for the single FIFO write port.
// The winner gets a one-cycle acknowledge and its payload is written through a
// registered wr_en/wr_data pair. A local occupancy counter tracks every issued
// write, including the one still sitting in the output register. Writes are
// therefore never issued into a full FIFO, and fifo_full is not needed.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous active-low reset
//   send_req      per-sender level request, held until the sender sees its ack
//   send_data     packed payloads, sender i at [i*DATA_WIDTH +: DATA_WIDTH]
//   send_ack      one-hot single-cycle pulse: the sender's word was written
//   fifo_wr_en    registered write enable to the FIFO
//   fifo_wr_data  registered write data to the FIFO (zero when idle)
//   fifo_rd_en    copy of the consumer's registered rd_en on the same FIFO
//   occupancy     local entry count, including the write in flight

module argo_chan_send_arb #(
  parameter int NUM_SENDERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 1 << ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SENDERS-1:0]            send_req,
  input  logic [NUM_SENDERS*DATA_WIDTH-1:0] send_data,
  output logic [NUM_SENDERS-1:0]            send_ack,
  output logic                              fifo_wr_en,
  output logic [DATA_WIDTH-1:0]             fifo_wr_data,
  input  logic                              fifo_rd_en,
  output logic [ADDR_WIDTH:0]               occupancy
);

  localparam int                  PTR_W     = $clog2(NUM_SENDERS);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]    LAST_IDX  = PTR_W'(NUM_SENDERS - 1);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_SENDERS-1:0] ack_q, ack_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]    occ_q, occ_d;

  logic [NUM_SENDERS-1:0] eligible;
  logic                   found;
  logic [PTR_W-1:0]       win;
  logic                   issue;
  logic                   rd;

  // A sender that was just acked is masked for one cycle. Its control loop
  // only drops req after seeing the ack, so without the mask the stale req
  // would be granted a second time.
  always_comb begin
    eligible = send_req & ~ack_q;
    found    = 1'b0;
    win      = '0;
    for (int k = 0; k < NUM_SENDERS; k++) begin
      automatic int               idx_int = (int'(ptr_q) + k) % NUM_SENDERS;
      automatic logic [PTR_W-1:0] idx     = idx_int[PTR_W-1:0];
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Occupancy already includes the write held in the output register.
  // When the count is at DEPTH, issue stays blocked even if a read happens
  // in the same cycle. Issue resumes one cycle later.
  always_comb begin
    issue = found && (occ_q < DEPTH_CNT);
    rd    = fifo_rd_en && (occ_q != '0);
  end

  always_comb begin
    ptr_d     = ptr_q;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    if (issue) begin
      ack_d[win] = 1'b1;
      wr_en_d    = 1'b1;
      wr_data_d  = send_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      ptr_d      = (win == LAST_IDX) ? '0 : win + PTR_W'(1);
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({issue, rd})
      2'b10:   occ_d = occ_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   occ_d = occ_q - (ADDR_WIDTH + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      occ_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      occ_q     <= occ_d;
    end
  end

  assign send_ack     = ack_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_argo_chan_send_arb.sv
// tb_argo_chan_send_arb
//
// Self-checking bench for argo_chan_send_arb (4 senders, 32-bit data, DEPTH 8).
// A behavioural model advances on every posedge from the sampled inputs.
// A compare process checks every DUT output against that model on each
// negedge. Directed steps pin the model to hand-computed values. A long
// randomized phase then follows, with blocking-send sender loops, random
// consumer reads and occasional resets.

module tb_argo_chan_send_arb;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  send_req;
  logic [N*DW-1:0] send_data;
  logic [N-1:0]  send_ack;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_rd_en;
  logic [AW:0]   occupancy;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Model state: pointer and occupancy as plain integers, plus the expected outputs.
  int           m_ptr  = 0;
  int           m_occ  = 0;
  logic [N-1:0] m_ack  = '0;
  bit           m_wr   = 1'b0;
  logic [DW-1:0] m_data = '0;

  argo_chan_send_arb #(
    .NUM_SENDERS(N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_req    (send_req),
    .send_data   (send_data),
    .send_ack    (send_ack),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en  (fifo_rd_en),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model. The first requesting sender at or after the pointer
  // wins, unless it was acked last cycle. Nothing is issued while the model
  // counts DEPTH entries. A read at zero occupancy is ignored.
  always @(posedge clk) begin
    logic [N-1:0] elig;
    int           w;
    bit           do_issue;
    bit           do_rd;
    if (!rst) begin
      m_ptr  = 0;
      m_occ  = 0;
      m_ack  = '0;
      m_wr   = 1'b0;
      m_data = '0;
    end else begin
      elig = send_req & ~m_ack;
      w    = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      do_issue = (w >= 0) && (m_occ < DEPTH);
      do_rd    = fifo_rd_en && (m_occ > 0);
      m_ack    = '0;
      if (do_issue) begin
        m_ack[w] = 1'b1;
        m_wr     = 1'b1;
        m_data   = send_data[w*DW +: DW];
        m_ptr    = (w + 1) % N;
      end else begin
        m_wr   = 1'b0;
        m_data = '0;
      end
      m_occ = m_occ + int'(do_issue) - int'(do_rd);
    end
  end

  // One comparison: counts a vector and reports any difference.
  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every output is checked against the model on each negedge.
  always @(negedge clk) begin
    if (check_en) begin
      compareField("model_ack",   64'(send_ack),     64'(m_ack));
      compareField("model_wr_en", 64'(fifo_wr_en),   64'(m_wr));
      compareField("model_data",  64'(fifo_wr_data), 64'(m_data));
      compareField("model_occ",   64'(occupancy),    64'(m_occ));
    end
  end

  // Directed check of all outputs against hand-computed literals.
  task automatic checkOutput(input string name, input logic [N-1:0] ea, input bit ew,
                             input logic [DW-1:0] ed, input int eo);
    compareField({name, "_ack"},  64'(send_ack),     64'(ea));
    compareField({name, "_wr"},   64'(fifo_wr_en),   64'(ew));
    compareField({name, "_data"}, 64'(fifo_wr_data), 64'(ed));
    compareField({name, "_occ"},  64'(occupancy),    64'(eo));
  endtask

  // Drive one cycle's inputs right after a negedge, then advance to the next negedge.
  task automatic applyStimulus(input logic [N-1:0] req, input bit rd, input bit r);
    send_req   = req;
    fifo_rd_en = rd;
    rst        = r;
    @(negedge clk);
  endtask

  task automatic setData(input int i, input logic [DW-1:0] v);
    send_data[i*DW +: DW] = v;
  endtask

  int acks;

  // Directed sequence first, then the randomized blocking-send traffic.
  initial begin
    rst        = 1'b0;
    send_req   = '0;
    send_data  = '0;
    fifo_rd_en = 1'b0;
    @(negedge clk);
    check_en = 1'b1;

    repeat (4) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("reset_hold", '0, 1'b0, '0, 0);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("idle_release", '0, 1'b0, '0, 0);

    setData(2, 32'h2A);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("s2_grant", 4'b0100, 1'b1, 32'h2A, 1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("s2_single", '0, 1'b0, '0, 1);

    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("reset_clear", '0, 1'b0, '0, 0);

    setData(0, 32'd10);
    setData(1, 32'd11);
    setData(3, 32'd13);
    applyStimulus(4'b1011, 1'b0, 1'b1);
    checkOutput("rr_first", 4'b0001, 1'b1, 32'd10, 1);
    applyStimulus(4'b1010, 1'b0, 1'b1);
    checkOutput("rr_second", 4'b0010, 1'b1, 32'd11, 2);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    checkOutput("rr_third", 4'b1000, 1'b1, 32'd13, 3);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("rr_gap", '0, 1'b0, '0, 3);

    // Pointer is back at 0, so sender 1 beats sender 3. The read in the same cycle keeps the count at 3.
    setData(1, 32'h77);
    setData(3, 32'h33);
    applyStimulus(4'b1010, 1'b1, 1'b1);
    checkOutput("issue_with_rd", 4'b0010, 1'b1, 32'h77, 3);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    checkOutput("ptr_next", 4'b1000, 1'b1, 32'h33, 4);

    repeat (4) applyStimulus('0, 1'b1, 1'b1);
    checkOutput("drained", '0, 1'b0, '0, 0);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("rd_at_empty", '0, 1'b0, '0, 0);

    // Sender 0 re-requests nonstop and is granted every other cycle until the FIFO holds DEPTH entries.
    setData(0, 32'hC0);
    acks = 0;
    repeat (20) begin
      applyStimulus(4'b0001, 1'b0, 1'b1);
      if (send_ack[0]) acks++;
    end
    compareField("fill_ack_count", 64'(acks), 64'(8));
    checkOutput("full_hold", '0, 1'b0, '0, 8);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("full_rd_no_issue", '0, 1'b0, '0, 7);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    checkOutput("refill", 4'b0001, 1'b1, 32'hC0, 8);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    checkOutput("full_again", '0, 1'b0, '0, 8);

    repeat (3) applyStimulus('0, 1'b1, 1'b1);
    checkOutput("occ_five", '0, 1'b0, '0, 5);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    checkOutput("reset_midop", '0, 1'b0, '0, 0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("restart_s0", 4'b0001, 1'b1, 32'hC0, 1);

    // Random traffic. Each sender holds req and data until it is acked. After
    // the ack it either re-requests with new data or goes quiet. The read
    // rate is low in the first half, so the FIFO fills and the full stall is
    // exercised often.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (send_req[i] && send_ack[i]) begin
          if ($urandom_range(1, 0) == 1) send_data[i*DW +: DW] = $urandom();
          else send_req[i] = 1'b0;
        end else if (!send_req[i] && $urandom_range(2, 0) == 0) begin
          send_req[i] = 1'b1;
          send_data[i*DW +: DW] = $urandom();
        end
      end
      fifo_rd_en = ($urandom_range(9, 0) < ((cyc < 1500) ? 3 : 6));
      rst        = ($urandom_range(299, 0) != 0);
      @(negedge clk);
    end

    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/argo_chan_send_arb.md
# argo_chan_send_arb

Round-robin send arbiter that sits directly upstream of one `argo_fifo` channel. It merges up to NUM_SENDERS go-routine send statements (control-bit loops) onto the single FIFO write port. It tracks channel occupancy locally so that a write is never issued into a full FIFO. Each winning sender gets a one-cycle acknowledge, which its control loop uses to advance past the blocking send.

## Interface
- NUM_SENDERS, 4, number of sender ports (2..16)
- DATA_WIDTH, 32, channel payload width; matches the FIFO's DATA_WIDTH
- ADDR_WIDTH, 4, matches the FIFO's ADDR_WIDTH
- DEPTH, 1<<ADDR_WIDTH, FIFO capacity in entries
- clk  in  1  system clock; all logic is on posedge
- rst  in  1  synchronous, active-low reset (rst==0 resets on a posedge)
- send_req  in  NUM_SENDERS  level request per sender; held until that sender's ack is seen
- send_data  in  NUM_SENDERS*DATA_WIDTH  payload; sender i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req is high
- send_ack  out  NUM_SENDERS  one-hot, one-cycle pulse; the sender's value was written
- fifo_wr_en  out  1  to the FIFO wr_en; registered
- fifo_wr_data  out  DATA_WIDTH  to the FIFO wr_data; registered
- fifo_rd_en  in  1  copy of the consumer's registered rd_en driving the same FIFO
- occupancy  out  ADDR_WIDTH+1  local entry count, including the write in flight

## Operation
- Reset values:
  - send_ack=0, fifo_wr_en=0, fifo_wr_data=0, occupancy=0.
  - Round-robin pointer ptr=0.
- Eligibility in cycle t: sender i is eligible when send_req[i]=1 and send_ack[i]=0. The ack mask prevents re-granting a sender before its control loop drops req.
- Issue condition: any sender eligible and occupancy < DEPTH.
- Winner selection: the first eligible index searching ptr, ptr+1, …, wrapping modulo NUM_SENDERS.
- On issue, at edge t+1:
  - fifo_wr_en=1; fifo_wr_data=send_data[winner].
  - send_ack[winner]=1.
  - ptr=(winner+1) mod NUM_SENDERS.
- No issue: fifo_wr_en=0, fifo_wr_data=0, send_ack=0, ptr unchanged.
- Occupancy update: occupancy_next = occupancy + issue − rd, where rd = fifo_rd_en && occupancy!=0.
  - Simultaneous issue and rd leaves occupancy unchanged.
  - fifo_rd_en at occupancy 0 is ignored; no underflow.
- At occupancy==DEPTH, no issue occurs, even if fifo_rd_en=1 in that same cycle. Issue resumes the cycle after occupancy drops.
- Senders that are not granted keep waiting, with no ack and no timeout. This is the blocking-send semantics.
- Reset mid-operation: any pending grant is dropped; occupancy returns to 0. The FIFO is reset on the same rst, so the two stay consistent.

## Timing
- Request-to-write latency: 1 cycle. A req first seen at edge t (eligible) produces wr_en and ack at edge t+1, with no contention and no backpressure.
- The FIFO stores the word at edge t+2, since it samples the registered wr_en.
- Throughput: at most one write per cycle; this is sustained when two or more senders alternate.
- A single sender that re-requests immediately gets one write every 2 cycles, because of the ack mask.
- fifo_full is not used. Because occupancy counts issued writes, the FIFO cannot overflow even with the 1-cycle wr_en register lag.
- No combinational path from any input to any output.

## Test plan
- Reset, then idle for 5 cycles with rst=0 → send_ack=0, fifo_wr_en=0, fifo_wr_data=0, occupancy=0. Release rst=1, no requests → outputs stay 0.
- Sender 2 raises req with data 0x2A at edge t and drops it after the ack → at edge t+1, send_ack=4'b0100, fifo_wr_en=1, fifo_wr_data=0x2A; occupancy=1; exactly one write.
- Senders 0, 1 and 3 all request and hold req until acked; data are 10, 11 and 13 → acks on three consecutive cycles in the order 0, 1, 3; FIFO writes 10, 11, 13; ptr ends at 0.
- DEPTH=4 with sender 0 re-requesting continuously and fifo_rd_en=0 → exactly 4 acks, then occupancy=4 and no further wr_en. One fifo_rd_en pulse → occupancy 3, then one more write; occupancy returns to 4.
- At occupancy 3, sender 1 issues while fifo_rd_en=1 in the same cycle → occupancy stays 3 and the write is accepted. A fifo_rd_en pulse at occupancy 0 → occupancy stays 0.
- rst driven to 0 while three senders are pending and occupancy=5 → at the next edge, acks=0, wr_en=0, occupancy=0. After release, arbitration restarts from sender 0.
